vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: hsync pulse width in clocks.
REQ-002 SHALL have parameter H_BP, default 48: horizontal back porch in clocks.
REQ-003 SHALL have parameter H_ACT, default 640: horizontal active width in clocks.
REQ-004 SHALL have parameter H_FP, default 16: horizontal front porch in clocks.
REQ-005 SHALL have parameters V_SYNC, V_BP, V_ACT and V_FP, defaults 2, 33, 480 and 10: vertical phase lengths in lines.
REQ-006 SHALL have parameters WIN_W and WIN_H, defaults 128 and 96: 1bpp window size at the top-left of the active area; WIN_W is a multiple of 32, WIN_W<=H_ACT and WIN_H<=V_ACT.
REQ-007 SHALL have parameter BASE_ADDR, default 32'h3E80: word address of window pixel (0,0).
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port en, input, 1 bit: scanout enable.
REQ-011 SHALL have ports mem_req (output, 1 bit) and mem_addr (output, 32 bits): the read request and its word address.
REQ-012 SHALL have ports mem_ack (input, 1 bit) and mem_rdata (input, 32 bits): the read acknowledge and its data word.
REQ-013 SHALL have ports hsync and vsync (outputs, 1 bit each): sync signals, active low.
REQ-014 SHALL have ports de (output, 1 bit) and pixel (output, 1 bit): window data enable and pixel value.
REQ-015 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first vsync-low cycle.
REQ-016 SHALL have port underrun, output, 1 bit: sticky line-fetch underrun flag.
REQ-017 SHALL have port vga_state, output, 2 bits: 0 = inactive, 1 = about to be active, 2 = active.
REQ-018 SHALL have ports h_count (output, 10 bits) and v_count (output, 9 bits): phase-relative counters.

Function
REQ-019 h FSM states SHALL be H_SYNC_S -> H_BP_S -> H_ACT_S -> H_FP_S -> H_SYNC_S; h_count SHALL run 0..len-1 in each state and return to 0 on each transition, so a line is H_SYNC+H_BP+H_ACT+H_FP clocks.
REQ-020 v FSM states SHALL be V_SYNC_S, V_BP_S, V_ACT_S and V_FP_S in that order; v_count SHALL increment on the last H_FP_S cycle and return to 0 at each v-state change.
REQ-021 With en=0 and the FSMs idle, counters SHALL hold at 0 in H_SYNC_S/V_SYNC_S with hsync=vsync=1, de=0 and mem_req=0; en=1 SHALL start the count on the next clock.
REQ-022 When en falls mid-frame, the current frame SHALL complete and the FSMs SHALL go idle after the last V_FP_S line.
REQ-023 hsync, vsync, de and pixel SHALL be registered and mutually aligned, one clock after the counter state that produces them.
REQ-024 de SHALL be 1 iff H_ACT_S, V_ACT_S, h_count<WIN_W and v_count<WIN_H; pixel SHALL be 0 whenever de=0.
REQ-025 vga_state SHALL be 2 in V_ACT_S, 1 during the last V_BP_S line, and 0 otherwise.
REQ-026 The block SHALL hold a two-bank line buffer, each bank WIN_W/32 words; window line y SHALL be displayed from bank y[0].
REQ-027 The fetch for line y SHALL start at the first H_FP_S cycle of the preceding line (the last V_BP_S line when y=0) and SHALL write bank y[0].
REQ-028 The fetch FSM SHALL have states F_IDLE, F_REQ and F_DONE.
REQ-029 In F_REQ, mem_req=1 and mem_addr=BASE_ADDR+y*(WIN_W/32)+k SHALL be held stable until mem_ack; the ack cycle SHALL capture mem_rdata into word k and increment k.
REQ-030 After word WIN_W/32-1 the fetch SHALL go to F_DONE; mem_ack while mem_req=0 SHALL be ignored.
REQ-031 Pixel x SHALL be bit x[4:0] of word x/32, with bit 0 displayed first.
REQ-032 If the line-y fetch is not in F_DONE at window line start (H_ACT_S, h_count=0), underrun SHALL set, that line SHALL output pixel=0, and the fetch SHALL abort to F_IDLE with mem_req deasserted the next clock.
REQ-033 underrun SHALL clear only on rst.
REQ-034 Simultaneous en fall and fetch completion SHALL still display the fetched line.

Reset
REQ-035 Reset SHALL be synchronous and active-high: FSMs to H_SYNC_S/V_SYNC_S/F_IDLE; counters and k to 0; hsync=vsync=1; de=pixel=mem_req=frame_start=underrun=0; vga_state=0; mem_addr=BASE_ADDR.
REQ-036 rst mid-transaction SHALL drop mem_req the next cycle, and any pending ack SHALL be ignored.

Structure
REQ-037 Package vga_pkg SHALL hold the h, v and fetch state enums and the vga_state code constants.
REQ-038 Sub-module vga_timing SHALL contain the h/v counters and FSMs plus en gating; the fetch, buffer and pixel logic SHALL sit in vga_scanout.

Verification (bench params: H 4/4/64/4, V 2/2/8/2, WIN 64x4, BASE_ADDR=0x100, 76 clocks/line)
REQ-039 Free run, ack=1 every cycle -> hsync low 4 clocks per 76, vsync low 152 clocks per 1064, frame_start once per 1064.
REQ-040 mem_rdata=32'h0000_0001 for every word -> pixel=1 at x=0 and x=32 on lines 0..3 only, 0 elsewhere, de high 64 clocks on 4 lines.
REQ-041 Ack delayed 3 cycles -> mem_addr stays at 0x100 until ack, then 0x101; line-1 fetch addresses 0x102 and 0x103.
REQ-042 No ack for line 2 -> underrun=1 at line-2 start, line 2 pixels 0, line 3 displays correctly, underrun stays 1.
REQ-043 rst asserted during F_REQ -> next cycle mem_req=0 and all outputs match REQ-035.
REQ-044 en dropped at v_count=3 of V_ACT_S -> frame completes, then idle with hsync=vsync=1; en=1 restarts at H_SYNC_S count 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared state encodings for the VGA scanout block.
// Imported by the timing generator and the scanout top.
package vga_pkg;

   typedef enum logic [1:0] {
      H_SYNC_S,
      H_BP_S,
      H_ACT_S,
      H_FP_S
   } h_state_e;

   typedef enum logic [1:0] {
      V_SYNC_S,
      V_BP_S,
      V_ACT_S,
      V_FP_S
   } v_state_e;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_DONE
   } f_state_e;

   localparam logic [1:0] VS_IDLE   = 2'd0;
   localparam logic [1:0] VS_SOON   = 2'd1;
   localparam logic [1:0] VS_ACTIVE = 2'd2;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical phase FSMs with enable gating.
// A started frame always runs to its end; en is sampled only when idle.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int H_ACT  = 640,
   parameter int H_FP   = 16,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int V_ACT  = 480,
   parameter int V_FP   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       run,
   output h_state_e   h_state,
   output v_state_e   v_state,
   output logic [9:0] h_count,
   output logic [8:0] v_count,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic [1:0] vga_state
);

   h_state_e   h_state_q, h_state_d;
   v_state_e   v_state_q, v_state_d;
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [8:0] v_cnt_q, v_cnt_d;
   logic       run_q, run_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       fs_q, fs_d;
   logic [9:0] h_end;
   logic [8:0] v_end;

   always_comb begin
      h_end = 10'(H_SYNC - 1);
      unique case (h_state_q)
         H_SYNC_S: h_end = 10'(H_SYNC - 1);
         H_BP_S:   h_end = 10'(H_BP - 1);
         H_ACT_S:  h_end = 10'(H_ACT - 1);
         H_FP_S:   h_end = 10'(H_FP - 1);
      endcase
      v_end = 9'(V_SYNC - 1);
      unique case (v_state_q)
         V_SYNC_S: v_end = 9'(V_SYNC - 1);
         V_BP_S:   v_end = 9'(V_BP - 1);
         V_ACT_S:  v_end = 9'(V_ACT - 1);
         V_FP_S:   v_end = 9'(V_FP - 1);
      endcase
   end

   always_comb begin
      h_state_d = h_state_q;
      v_state_d = v_state_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      run_d     = run_q;
      if (!run_q) begin
         run_d = en;
      end else if (h_cnt_q != h_end) begin
         h_cnt_d = h_cnt_q + 10'd1;
      end else begin
         h_cnt_d   = '0;
         h_state_d = h_state_e'(h_state_q + 2'd1);
         if (h_state_q == H_FP_S) begin
            if (v_cnt_q != v_end) begin
               v_cnt_d = v_cnt_q + 9'd1;
            end else begin
               v_cnt_d   = '0;
               v_state_d = v_state_e'(v_state_q + 2'd1);
               if (v_state_q == V_FP_S) run_d = en;
            end
         end
      end
      hsync_d = ~(run_q && h_state_q == H_SYNC_S);
      vsync_d = ~(run_q && v_state_q == V_SYNC_S);
      fs_d    = run_q && v_state_q == V_SYNC_S
             && h_state_q == H_SYNC_S
             && v_cnt_q == '0 && h_cnt_q == '0;
   end

   always_comb begin
      vga_state = VS_IDLE;
      if (v_state_q == V_ACT_S) begin
         vga_state = VS_ACTIVE;
      end else if (v_state_q == V_BP_S && v_cnt_q == v_end) begin
         vga_state = VS_SOON;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_state_q <= H_SYNC_S;
         v_state_q <= V_SYNC_S;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         run_q     <= 1'b0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         fs_q      <= 1'b0;
      end else begin
         h_state_q <= h_state_d;
         v_state_q <= v_state_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         run_q     <= run_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         fs_q      <= fs_d;
      end
   end

   assign run         = run_q;
   assign h_state     = h_state_q;
   assign v_state     = v_state_q;
   assign h_count     = h_cnt_q;
   assign v_count     = v_cnt_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = fs_q;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 1bpp window scanout with a ping-pong line buffer
// refilled from word memory during the preceding line's blanking.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          H_ACT     = 640,
   parameter int          H_FP      = 16,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          V_ACT     = 480,
   parameter int          V_FP      = 10,
   parameter int          WIN_W     = 128,
   parameter int          WIN_H     = 96,
   parameter logic [31:0] BASE_ADDR = 32'h3E80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        pixel,
   output logic        frame_start,
   output logic        underrun,
   output logic [1:0]  vga_state,
   output logic [9:0]  h_count,
   output logic [8:0]  v_count
);

   localparam int            WORDS   = WIN_W / 32;
   localparam int            KW      = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST  = KW'(WORDS - 1);
   localparam logic [9:0]    WIN_W_C = 10'(WIN_W);
   localparam logic [8:0]    WIN_H_C = 9'(WIN_H);

   logic          run;
   h_state_e      h_state;
   v_state_e      v_state;
   f_state_e      f_state_q, f_state_d;
   logic [KW-1:0] k_q, k_d;
   logic [8:0]    fy_q, fy_d;
   logic          line_ok_q, line_ok_d;
   logic          underrun_q, underrun_d;
   logic          de_q, de_d;
   logic          pixel_q, pixel_d;
   logic          in_win, line_start, fetch_go;
   logic          fetch_ready, cur_ok, wr_en;
   logic [8:0]    fetch_y;
   logic [KW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic [31:0]   lbuf_q [2][WORDS];

   vga_timing #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .run         (run),
      .h_state     (h_state),
      .v_state     (v_state),
      .h_count     (h_count),
      .v_count     (v_count),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .vga_state   (vga_state)
   );

   assign in_win = run && h_state == H_ACT_S
                && v_state == V_ACT_S
                && h_count < WIN_W_C
                && v_count < WIN_H_C;
   assign line_start = in_win && h_count == '0;

   // Line 0 is fetched during the last back-porch line.
   assign fetch_go = run && h_state == H_FP_S && h_count == '0
                  && (vga_state == VS_SOON
                   || (v_state == V_ACT_S
                    && v_count < WIN_H_C - 9'd1));
   assign fetch_y = (vga_state == VS_SOON) ? 9'd0
                                           : v_count + 9'd1;

   assign fetch_ready = f_state_q == F_DONE && fy_q == v_count;
   assign cur_ok      = (h_count == '0) ? fetch_ready : line_ok_q;
   assign rd_idx      = h_count[KW+4:5];
   assign rd_word     = lbuf_q[v_count[0]][rd_idx];

   always_comb begin
      f_state_d  = f_state_q;
      k_d        = k_q;
      fy_d       = fy_q;
      line_ok_d  = line_ok_q;
      underrun_d = underrun_q;
      wr_en      = 1'b0;
      if (line_start) begin
         line_ok_d = fetch_ready;
         if (!fetch_ready) underrun_d = 1'b1;
         f_state_d = F_IDLE;
      end else if (fetch_go) begin
         f_state_d = F_REQ;
         k_d       = '0;
         fy_d      = fetch_y;
      end else if (f_state_q == F_REQ && mem_ack) begin
         wr_en = 1'b1;
         k_d   = k_q + 1'b1;
         if (k_q == K_LAST) f_state_d = F_DONE;
      end
      de_d    = in_win;
      pixel_d = in_win && cur_ok && rd_word[h_count[4:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_state_q  <= F_IDLE;
         k_q        <= '0;
         fy_q       <= '0;
         line_ok_q  <= 1'b0;
         underrun_q <= 1'b0;
         de_q       <= 1'b0;
         pixel_q    <= 1'b0;
      end else begin
         f_state_q  <= f_state_d;
         k_q        <= k_d;
         fy_q       <= fy_d;
         line_ok_q  <= line_ok_d;
         underrun_q <= underrun_d;
         de_q       <= de_d;
         pixel_q    <= pixel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) lbuf_q[fy_q[0]][k_q] <= mem_rdata;
   end

   assign mem_req  = f_state_q == F_REQ;
   assign mem_addr = BASE_ADDR + 32'(fy_q) * 32'(WORDS) + 32'(k_q);
   assign de       = de_q;
   assign pixel    = pixel_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench; expected lines and fetch
// addresses are queued by the stimulus and popped by monitors.
module tb_vga_scanout;

   logic        clk, rst, en;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_rdata;
   logic        hsync, vsync, de, pixel, frame_start, underrun;
   logic [1:0]  vga_state;
   logic [9:0]  h_count;
   logic [8:0]  v_count;

   int n_chk = 0;
   int n_fail = 0;

   logic [63:0] lq[$];
   logic [31:0] aq[$];

   int ack_delay = 0;
   bit tmode = 0, block2 = 0, block_all = 0, force_ack = 0;
   int wcnt = 0;
   int pix_bad = 0, stab_bad = 0;

   logic [31:0] dtab [8] = '{
      32'h0000_0001, 32'h8000_0000, 32'hF0F0_1234, 32'h0F0F_8421,
      32'hDEAD_BEEF, 32'h1234_5678, 32'hAAAA_5555, 32'h0000_FFFF
   };

   vga_scanout #(
      .H_SYNC(4), .H_BP(4), .H_ACT(64), .H_FP(4),
      .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(2),
      .WIN_W(64), .WIN_H(4), .BASE_ADDR(32'h100)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
      .frame_start(frame_start), .underrun(underrun),
      .vga_state(vga_state), .h_count(h_count), .v_count(v_count)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Memory responder: acks after ack_delay wait cycles.
   initial begin
      mem_ack = 0;
      mem_rdata = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_rdata = tmode ? dtab[mem_addr[2:0]] : 32'h1;
         if (force_ack) begin
            mem_ack = 1;
         end else if (mem_req && !block_all
                      && !(block2 && (mem_addr == 32'h104
                                   || mem_addr == 32'h105))) begin
            if (wcnt >= ack_delay) begin
               mem_ack = 1;
               wcnt = 0;
            end else begin
               mem_ack = 0;
               wcnt++;
            end
         end else begin
            mem_ack = 0;
            wcnt = 0;
         end
      end
   end

   logic [63:0] line_v = '0;
   int px = 0, line_no = 0;
   bit in_line = 0;

   always @(negedge clk) begin
      if (de !== 1'b1 && pixel === 1'b1) pix_bad++;
      if (de === 1'b1) begin
         if (px < 64) line_v[px] = pixel;
         px++;
         in_line = 1;
      end else if (in_line) begin
         in_line = 0;
         if (lq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL line_unexpected: got line %0d expected none",
                     line_no);
         end else begin
            check($sformatf("line%0d_pixels", line_no), line_v,
                  lq.pop_front());
            check($sformatf("line%0d_de_len", line_no), px, 64);
         end
         line_no++;
         px = 0;
         line_v = '0;
      end
   end

   bit a_wait = 0;
   logic [31:0] a_prev = '0;

   always @(negedge clk) begin
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
         if (aq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL addr_unexpected: got %h expected none",
                     mem_addr);
         end else begin
            check("fetch_addr", mem_addr, aq.pop_front());
         end
      end
      if (a_wait && mem_req === 1'b1 && mem_addr !== a_prev) stab_bad++;
      a_wait = (mem_req === 1'b1) && (mem_ack !== 1'b1);
      a_prev = mem_addr;
   end

   task automatic push_frame(input bit tm, input int skip);
      for (int y = 0; y < 4; y++) begin
         if (y == skip) begin
            lq.push_back(64'h0);
         end else begin
            lq.push_back(tm ? {dtab[2*y+1], dtab[2*y]}
                            : 64'h0000_0001_0000_0001);
            aq.push_back(32'h100 + 32'(2*y));
            aq.push_back(32'h101 + 32'(2*y));
         end
      end
   endtask

   task automatic wait_fs(input string nm);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (frame_start !== 1'b1 && i < 1200);
      check(nm, frame_start, 1);
   endtask

   task automatic rst_checks(input string t);
      check({t, "_hsync"}, hsync, 1);
      check({t, "_vsync"}, vsync, 1);
      check({t, "_de"}, de, 0);
      check({t, "_pixel"}, pixel, 0);
      check({t, "_mem_req"}, mem_req, 0);
      check({t, "_frame_start"}, frame_start, 0);
      check({t, "_underrun"}, underrun, 0);
      check({t, "_vga_state"}, vga_state, 0);
      check({t, "_mem_addr"}, mem_addr, 32'h100);
      check({t, "_h_count"}, h_count, 0);
      check({t, "_v_count"}, v_count, 0);
   endtask

   int hs, vs, fs, dc, f0, f1, n;
   bit ph;

   initial begin
      rst = 1;
      en = 0;
      repeat (3) @(negedge clk);
      rst_checks("reset");
      rst = 0;
      repeat (5) @(negedge clk);
      check("idle_h_count", h_count, 0);
      check("idle_hsync", hsync, 1);
      check("idle_mem_req", mem_req, 0);

      push_frame(0, -1);
      en = 1;
      wait_fs("f1_start");
      hs = 0; vs = 0; fs = 0; dc = 0; f0 = -1; f1 = -1; ph = 1;
      for (int i = 0; i < 1064; i++) begin
         if (i > 0) @(negedge clk);
         if (hsync === 1'b0 && ph) begin
            if (f0 < 0) f0 = i;
            else if (f1 < 0) f1 = i;
         end
         ph = (hsync !== 1'b0);
         hs += (hsync === 1'b0) ? 1 : 0;
         vs += (vsync === 1'b0) ? 1 : 0;
         fs += (frame_start === 1'b1) ? 1 : 0;
         dc += (de === 1'b1) ? 1 : 0;
      end
      check("f1_hsync_low", hs, 56);
      check("f1_vsync_low", vs, 152);
      check("f1_frame_start", fs, 1);
      check("f1_de_cycles", dc, 256);
      check("f1_hsync_period", f1 - f0, 76);
      @(negedge clk);
      check("f2_frame_period", frame_start, 1);

      tmode = 1;
      ack_delay = 3;
      push_frame(1, -1);
      wait_fs("f3_start");

      ack_delay = 0;
      block2 = 1;
      push_frame(1, 2);
      check("f3_underrun_clear", underrun, 0);
      n = 0;
      while (underrun !== 1'b1 && n < 1100) begin
         @(negedge clk);
         n++;
      end
      check("underrun_set", underrun, 1);
      check("underrun_line", v_count, 2);
      check("underrun_vstate", vga_state, 2);
      wait_fs("f4_start");
      check("underrun_sticky", underrun, 1);

      block2 = 0;
      push_frame(1, -1);
      n = 0;
      while (!(vga_state === 2'd2 && v_count === 9'd3) && n < 1100) begin
         @(negedge clk);
         n++;
      end
      check("en_drop_line", v_count, 3);
      en = 0;
      fs = 0;
      repeat (1100) begin
         @(negedge clk);
         fs += (frame_start === 1'b1) ? 1 : 0;
      end
      check("stop_no_frame", fs, 0);
      check("stop_h_count", h_count, 0);
      check("stop_v_count", v_count, 0);
      check("stop_hsync", hsync, 1);
      check("stop_vsync", vsync, 1);
      check("stop_de", de, 0);
      check("stop_mem_req", mem_req, 0);
      check("stop_underrun", underrun, 1);
      check("lines_shown", line_no, 16);

      en = 1;
      @(negedge clk);
      check("restart_h0", h_count, 0);
      check("restart_hsync_hi", hsync, 1);
      @(negedge clk);
      check("restart_h1", h_count, 1);
      check("restart_hsync_lo", hsync, 0);
      check("restart_fs", frame_start, 1);

      block_all = 1;
      n = 0;
      while (mem_req !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_req", mem_req, 1);
      rst = 1;
      en = 0;
      @(negedge clk);
      rst_checks("rst_mid");
      force_ack = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      check("post_rst_req", mem_req, 0);
      check("post_rst_addr", mem_addr, 32'h100);
      check("post_rst_underrun", underrun, 0);
      force_ack = 0;
      block_all = 0;

      check("lines_left", lq.size(), 0);
      check("addrs_left", aq.size(), 0);
      check("pixel_outside_de", pix_bad, 0);
      check("addr_stable", stab_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
